apb_master_arbiter: RTL and testbench



---
 rtl/apb_master_arbiter.sv | 129 ++++++++++++
 tb/tb_apb_master_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between two requesters with round-robin arbitration and an ACCESS timeout.
// Latency: grant at N, SETUP N+1, ACCESS N+2, rvalid N+3 with a zero-wait slave; each wait state adds a cycle.
// Backpressure: requests are held until gnt_o; pready_i stretches ACCESS until it is seen or the timeout aborts.
module apb_master_arbiter #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [1:0]                          req_i,
    input  logic [1:0][APB_ADDR_WIDTH-1:0]      addr_i,
    input  logic [1:0]                          we_i,
    input  logic [1:0][APB_DATA_WIDTH-1:0]      wdata_i,
    output logic [1:0]                          gnt_o,
    output logic [1:0]                          rvalid_o,
    output logic [APB_DATA_WIDTH-1:0]           rdata_o,
    output logic                                err_o,
    output logic [APB_ADDR_WIDTH-1:0]           paddr_o,
    output logic [APB_DATA_WIDTH-1:0]           pwdata_o,
    output logic                                pwrite_o,
    output logic                                psel_o,
    output logic                                penable_o,
    input  logic                                pready_i,
    input  logic [APB_DATA_WIDTH-1:0]           prdata_i,
    input  logic                                pslverr_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             rr_ptr_q;
    logic             owner_q;
    logic             win;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_hit;
    logic             xfer_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        gnt_o       = 2'b00;
        state_d     = state_q;
        xfer_done   = 1'b0;
        win         = req_i[1];
        if (&req_i) begin
            win = rr_ptr_q;
        end
        // cnt_q counts the wait cycles already spent; this cycle is the last one allowed
        timeout_hit = TIMEOUT_EN && !pready_i && (cnt_q == CNT_LAST);
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_o[win] = 1'b1;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_i || timeout_hit) begin
                    xfer_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign psel_o    = (state_q != IDLE);
    assign penable_o = (state_q == ACCESS);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            paddr_o  <= '0;
            pwdata_o <= '0;
            pwrite_o <= 1'b0;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            rvalid_o <= 2'b00;
            rdata_o  <= '0;
            err_o    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            rvalid_o <= 2'b00;
            if (|gnt_o) begin
                paddr_o  <= addr_i[win];
                pwdata_o <= wdata_i[win];
                pwrite_o <= we_i[win];
                owner_q  <= win;
                rr_ptr_q <= ~win;
            end
            if (xfer_done) begin
                rvalid_o[owner_q] <= 1'b1;
                if (pready_i) begin
                    rdata_o <= pwrite_o ? '0 : prdata_i;
                    err_o   <= pslverr_i;
                end else begin
                    rdata_o <= '0;
                    err_o   <= 1'b1;
                end
            end
            if (TIMEOUT_EN && (state_q == ACCESS) && !pready_i && !timeout_hit) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: two instances (timeout 4 and timeout disabled) driven by a
// transaction-level reference model of arbitration order, APB phases and responses.
module tb_apb_master_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       req     [2];
    logic [1:0][31:0] addr    [2];
    logic [1:0]       we      [2];
    logic [1:0][31:0] wdata   [2];
    logic [1:0]       gnt     [2];
    logic [1:0]       rvalid  [2];
    logic [31:0]      rdata   [2];
    logic             err     [2];
    logic [31:0]      paddr   [2];
    logic [31:0]      pwdata  [2];
    logic             pwrite  [2];
    logic             psel    [2];
    logic             penable [2];
    logic             pready  [2];
    logic [31:0]      prdata  [2];
    logic             pslverr [2];

    apb_master_arbiter #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]),
        .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
        .err_o(err[0]), .paddr_o(paddr[0]), .pwdata_o(pwdata[0]), .pwrite_o(pwrite[0]),
        .psel_o(psel[0]), .penable_o(penable[0]), .pready_i(pready[0]),
        .prdata_i(prdata[0]), .pslverr_i(pslverr[0])
    );

    apb_master_arbiter #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]),
        .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
        .err_o(err[1]), .paddr_o(paddr[1]), .pwdata_o(pwdata[1]), .pwrite_o(pwrite[1]),
        .psel_o(psel[1]), .penable_o(penable[1]), .pready_i(pready[1]),
        .prdata_i(prdata[1]), .pslverr_i(pslverr[1])
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model state, per instance
    int          ptr_m   [2];
    bit          pend_v  [2];
    int          pend_o  [2];
    logic [31:0] last_rd [2];
    logic        last_e  [2];

    function automatic int tmo(input int d);
        return (d == 0) ? 4 : 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ptr_m[d]   = 0;
            pend_v[d]  = 0;
            pend_o[d]  = 0;
            last_rd[d] = '0;
            last_e[d]  = 1'b0;
        end
    endtask

    // registered checks for an IDLE cycle; call at the negedge
    task automatic check_idle(input int d);
        chk("rvalid", {62'd0, rvalid[d]}, pend_v[d] ? (64'd1 << pend_o[d]) : 64'd0);
        chk("rdata", {32'd0, rdata[d]}, {32'd0, last_rd[d]});
        chk("err", {63'd0, err[d]}, {63'd0, last_e[d]});
        chk("psel_idle", {63'd0, psel[d]}, 64'd0);
        pend_v[d] = 0;
    endtask

    task automatic idle_cycle(input int d);
        @(negedge clk);
        check_idle(d);
        req[d]    = 2'b00;
        pready[d] = 1'($urandom);
        #1;
        chk("gnt_idle", {62'd0, gnt[d]}, 64'd0);
    endtask

    task automatic xfer(input int d, input logic [1:0] reqv, input logic [1:0] we2,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input int waits, input logic slverr, input logic [31:0] prd);
        int          win;
        logic [31:0] ea;
        logic [31:0] ew;
        logic        ewr;
        bit          done;
        int          k;
        win = (reqv == 2'b11) ? ptr_m[d] : ((reqv == 2'b10) ? 1 : 0);
        ea  = win ? a1 : a0;
        ew  = win ? w1 : w0;
        ewr = we2[win];
        // IDLE: arbitration
        @(negedge clk);
        check_idle(d);
        req[d]      = reqv;
        we[d]       = we2;
        addr[d][0]  = a0;
        addr[d][1]  = a1;
        wdata[d][0] = w0;
        wdata[d][1] = w1;
        pready[d]   = 1'($urandom);
        #1;
        chk("gnt", {62'd0, gnt[d]}, 64'd1 << win);
        ptr_m[d] = 1 - win;
        // SETUP: pready is irrelevant here, new requests must wait
        @(negedge clk);
        chk("setup_psel", {63'd0, psel[d]}, 64'd1);
        chk("setup_penable", {63'd0, penable[d]}, 64'd0);
        chk("setup_paddr", {32'd0, paddr[d]}, {32'd0, ea});
        chk("setup_pwdata", {32'd0, pwdata[d]}, {32'd0, ew});
        chk("setup_pwrite", {63'd0, pwrite[d]}, {63'd0, ewr});
        chk("setup_rvalid", {62'd0, rvalid[d]}, 64'd0);
        req[d]    = 2'($urandom);
        pready[d] = 1'($urandom);
        #1;
        chk("gnt_setup", {62'd0, gnt[d]}, 64'd0);
        // ACCESS
        done = 0;
        k    = 0;
        while (!done) begin
            @(negedge clk);
            chk("acc_psel", {63'd0, psel[d]}, 64'd1);
            chk("acc_penable", {63'd0, penable[d]}, 64'd1);
            chk("acc_paddr", {32'd0, paddr[d]}, {32'd0, ea});
            chk("acc_pwdata", {32'd0, pwdata[d]}, {32'd0, ew});
            pready[d]  = (k == waits);
            prdata[d]  = prd;
            pslverr[d] = (k == waits) ? slverr : 1'($urandom);
            req[d]     = 2'($urandom);
            #1;
            chk("gnt_access", {62'd0, gnt[d]}, 64'd0);
            if (k == waits) begin
                last_rd[d] = ewr ? 32'd0 : prd;
                last_e[d]  = slverr;
                done       = 1;
            end else if (tmo(d) != 0 && k == tmo(d) - 1) begin
                last_rd[d] = 32'd0;
                last_e[d]  = 1'b1;
                done       = 1;
            end
            k++;
        end
        pend_v[d] = 1;
        pend_o[d] = win;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; addr[d] = '0; we[d] = '0; wdata[d] = '0;
            pready[d] = 1'b0; prdata[d] = '0; pslverr[d] = 1'b0;
        end
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_psel", {63'd0, psel[d]}, 64'd0);
            chk("rst_penable", {63'd0, penable[d]}, 64'd0);
            chk("rst_pwrite", {63'd0, pwrite[d]}, 64'd0);
            chk("rst_paddr", {32'd0, paddr[d]}, 64'd0);
            chk("rst_pwdata", {32'd0, pwdata[d]}, 64'd0);
            chk("rst_rvalid", {62'd0, rvalid[d]}, 64'd0);
            chk("rst_rdata", {32'd0, rdata[d]}, 64'd0);
            chk("rst_err", {63'd0, err[d]}, 64'd0);
        end
        rst = 1'b0;

        // round robin with both requesting: grants every third cycle, 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            xfer(0, 2'b11, 2'($urandom), $urandom, $urandom, $urandom, $urandom, 0, 1'b0, $urandom);
        end
        idle_cycle(0);

        // single zero-wait read
        xfer(0, 2'b01, 2'b00, 32'h1A10_0008, 32'h0, 32'h0, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
        idle_cycle(0);

        // timeout after 4 stuck ACCESS cycles, then a normal transfer
        xfer(0, 2'b10, 2'b00, 32'h0, 32'h4000_0010, 32'h0, 32'h0, 50, 1'b0, 32'h1234_5678);
        xfer(0, 2'b10, 2'b00, 32'h0, 32'h4000_0014, 32'h0, 32'h0, 1, 1'b0, 32'h8765_4321);
        idle_cycle(0);

        // write with 5 wait states ending in PSLVERR (timeout disabled instance)
        xfer(1, 2'b10, 2'b10, 32'h0, 32'h5000_0020, 32'h0, 32'hDEAD_BEEF, 5, 1'b1, 32'hFFFF_FFFF);
        idle_cycle(1);

        // 1000 wait cycles with the timeout disabled
        xfer(1, 2'b01, 2'b00, 32'h6000_0000, 32'h0, 32'h0, 32'h0, 1000, 1'b0, 32'h0BAD_CAFE);
        idle_cycle(1);

        // randomized traffic
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                logic [1:0] rv;
                rv = 2'($urandom);
                if (rv == 2'b00) begin
                    idle_cycle(d);
                end else begin
                    xfer(d, rv, 2'($urandom), $urandom, $urandom, $urandom, $urandom,
                         $urandom_range(0, 6), 1'($urandom), $urandom);
                end
            end
            idle_cycle(d);
        end

        // asynchronous reset in ACCESS, pointer left at requester 1 beforehand
        @(negedge clk);
        check_idle(0);
        req[0] = 2'b01;
        #1;
        chk("pre_rst_gnt", {62'd0, gnt[0]}, 64'd1 << ptr_m[0] * 0);
        @(negedge clk);
        req[0]    = 2'b00;
        pready[0] = 1'b0;
        @(negedge clk);
        chk("pre_rst_penable", {63'd0, penable[0]}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_psel", {63'd0, psel[0]}, 64'd0);
        chk("arst_penable", {63'd0, penable[0]}, 64'd0);
        @(negedge clk);
        chk("arst_rvalid", {62'd0, rvalid[0]}, 64'd0);
        chk("arst_rdata", {32'd0, rdata[0]}, 64'd0);
        rst = 1'b0;
        model_reset();
        xfer(0, 2'b11, 2'b11, 32'hA0, 32'hA4, 32'h11, 32'h22, 0, 1'b0, 32'h0);
        idle_cycle(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
